// File: rtl/time_ctrl_pkg.sv
// Shared types for the time-setting controller: FSM states, field-select codes
// and the small state helpers used by the controller.
package time_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_HOUR,
    SET_MIN,
    SET_SEC,
    COMMIT
  } state_e;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HOUR = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_SEC  = 2'd3
  } field_e;

  function automatic logic is_set(state_e s);
    return (s == SET_HOUR) || (s == SET_MIN) || (s == SET_SEC);
  endfunction

  function automatic state_e next_field(state_e s);
    case (s)
      SET_HOUR: return SET_MIN;
      SET_MIN:  return SET_SEC;
      default:  return SET_HOUR;
    endcase
  endfunction

  function automatic field_e field_of(state_e s);
    case (s)
      SET_HOUR: return FIELD_HOUR;
      SET_MIN:  return FIELD_MIN;
      SET_SEC:  return FIELD_SEC;
      default:  return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_key_repeat.sv
// Hold-to-auto-repeat: first pulse after HOLD_CYC cycles of lvl, then one every
// REPEAT_CYC cycles while lvl stays high. rep_pulse is combinational.
module key_repeat
  import time_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic lvl,
  output logic rep_pulse
);

  localparam int unsigned MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned W = $clog2(MAX_CYC + 1);
  localparam logic [W-1:0] HOLD_T = W'(HOLD_CYC);
  localparam logic [W-1:0] REP_T  = W'(REPEAT_CYC);

  logic [W-1:0] cnt_q, cnt_d, cnt_inc, term;
  logic         rpt_q, rpt_d, hit;

  // Terminal count switches from the initial hold to the repeat period after the first hit.
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    term    = rpt_q ? REP_T : HOLD_T;
    hit     = lvl && !clr && (cnt_inc == term);
    cnt_d   = cnt_inc;
    rpt_d   = rpt_q;
    if (clr || !lvl) begin
      cnt_d = '0;
      rpt_d = 1'b0;
    end else if (hit) begin
      cnt_d = '0;
      rpt_d = 1'b1;
    end
  end

  assign rep_pulse = hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rpt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rpt_q <= rpt_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: key handling FSM, idle timeout, blink and registered
// increment/commit pulses for the time-set datapath.
module time_set_ctrl
  import time_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC    = 50_000_000,
  parameter int unsigned REPEAT_CYC  = 10_000_000,
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned BLINK_CYC   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_up_lvl,
  input  logic       key_ok,
  output logic       hour_up,
  output logic       min_up,
  output logic       sec_up,
  output logic       enter,
  output logic       run_en,
  output logic [1:0] field_sel,
  output logic       blink
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BW = $clog2(BLINK_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_CYC - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;
  logic          hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic          enter_q, run_en_q;
  field_e        field_q;
  logic          in_set, entering, activity, tmo_hit, inc, rep_pulse, rep_clr;

  key_repeat #(
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC)
  ) u_key_repeat (
    .clk      (clk),
    .rst      (rst),
    .clr      (rep_clr),
    .lvl      (key_up_lvl),
    .rep_pulse(rep_pulse)
  );

  // Next state and timeout; kept apart from the pulse logic so the repeat
  // clear -> rep_pulse path through the sub-module is not a block-level loop.
  always_comb begin
    in_set   = is_set(state_q);
    activity = key_mode | key_up | key_ok | key_up_lvl;
    tmo_hit  = in_set && !activity && (tmo_q == TMO_LAST);
    state_d  = state_q;
    case (state_q)
      RUN:                        if (key_mode) state_d = SET_HOUR;
      SET_HOUR, SET_MIN, SET_SEC: begin
        if (key_ok)        state_d = COMMIT;
        else if (key_mode) state_d = next_field(state_q);
        else if (tmo_hit)  state_d = RUN;
      end
      default:                    state_d = RUN;
    endcase
    entering = is_set(state_d) && (state_d != state_q);
    rep_clr  = !in_set || (state_d != state_q);
    tmo_d    = tmo_q + 1'b1;
    if (!is_set(state_d) || entering || activity) tmo_d = '0;
  end

  always_comb begin
    inc     = in_set && !key_ok && !key_mode && (key_up || rep_pulse);
    hour_d  = inc && (state_q == SET_HOUR);
    min_d   = inc && (state_q == SET_MIN);
    sec_d   = inc && (state_q == SET_SEC);
    blink_d = blink_q;
    bcnt_d  = bcnt_q + 1'b1;
    // Entry blanks the field; an increment shows it and restarts the phase.
    if (!is_set(state_d)) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if (entering) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (inc) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if (bcnt_q == BLK_LAST) begin
      blink_d = ~blink_q;
      bcnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      tmo_q    <= '0;
      bcnt_q   <= '0;
      blink_q  <= 1'b0;
      hour_q   <= 1'b0;
      min_q    <= 1'b0;
      sec_q    <= 1'b0;
      enter_q  <= 1'b0;
      run_en_q <= 1'b1;
      field_q  <= FIELD_NONE;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      bcnt_q   <= bcnt_d;
      blink_q  <= blink_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      enter_q  <= (state_d == COMMIT);
      run_en_q <= (state_d == RUN);
      field_q  <= field_of(state_d);
    end
  end

  assign hour_up   = hour_q;
  assign min_up    = min_q;
  assign sec_up    = sec_q;
  assign enter     = enter_q;
  assign run_en    = run_en_q;
  assign field_sel = field_q;
  assign blink     = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl with small timing parameters.
module tb_time_set_ctrl;

  localparam int unsigned HOLD = 4, REP = 2, TMO = 20, BLK = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1, key_mode = 1'b0, key_up = 1'b0, key_up_lvl = 1'b0, key_ok = 1'b0;
  logic       hour_up, min_up, sec_up, enter, run_en, blink;
  logic [1:0] field_sel;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .HOLD_CYC   (HOLD),
    .REPEAT_CYC (REP),
    .TIMEOUT_CYC(TMO),
    .BLINK_CYC  (BLK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_mode  (key_mode),
    .key_up    (key_up),
    .key_up_lvl(key_up_lvl),
    .key_ok    (key_ok),
    .hour_up   (hour_up),
    .min_up    (min_up),
    .sec_up    (sec_up),
    .enter     (enter),
    .run_en    (run_en),
    .field_sel (field_sel),
    .blink     (blink)
  );

  typedef struct packed {logic rst, mode, up, lvl, ok;} in_t;
  typedef struct packed {logic h, m, s, en, run; logic [1:0] fs; logic bl;} out_t;
  typedef struct packed {in_t i; out_t o;} vec_t;

  int errors = 0;
  int checks = 0;
  out_t  exp_q[$];
  string name_q[$];
  vec_t  tbl[$];
  string tnm[$];

  localparam in_t  NOP  = 5'b00000;
  localparam in_t  MD   = 5'b01000;
  localparam in_t  UP   = 5'b00100;
  localparam in_t  LVL  = 5'b00010;
  localparam in_t  OK   = 5'b00001;
  localparam out_t RUNO = 8'b00001_00_0;
  localparam out_t COMO = 8'b00010_00_0;

  function automatic out_t os(input logic [1:0] f, input logic b);
    return {5'b00000, f, b};
  endfunction

  function automatic out_t op(input logic h, input logic m, input logic s,
                              input logic [1:0] f, input logic b);
    return {h, m, s, 2'b00, f, b};
  endfunction

  task automatic check_out();
    out_t  act, e;
    string nm;
    act = {hour_up, min_up, sec_up, enter, run_en, field_sel, blink};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expected value queued, got %b", act);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %b required %b (h m s en run fs[1:0] bl)", nm, act, e);
      end
    end
  endtask

  task automatic apply(input in_t i, input out_t e, input string nm);
    @(negedge clk);
    {rst, key_mode, key_up, key_up_lvl, key_ok} = i;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic add(input in_t i, input out_t o, input string nm);
    tbl.push_back({i, o});
    tnm.push_back(nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset state
    apply(5'b10000, RUNO, "reset0");
    apply(5'b10000, RUNO, "reset1");
    apply(NOP, RUNO, "idle after reset");

    // test 1: set hour three times and commit
    add(MD, os(2'd1, 1'b1), "t1 mode");
    for (int k = 1; k <= 3; k++) add(UP, op(1, 0, 0, 2'd1, 1'b0), $sformatf("t1 up%0d", k));
    add(OK, COMO, "t1 ok");
    add(NOP, RUNO, "t1 run");
    // keys other than mode are ignored in RUN
    add(UP, RUNO, "run up");
    add(LVL, RUNO, "run lvl");
    add(OK, RUNO, "run ok");
    add(5'b00111, RUNO, "run up+lvl+ok");
    // test 2: field cycling, min_up only in SET_MIN, blink phase
    add(MD, os(2'd1, 1'b1), "t2 mode hour");
    add(MD, os(2'd2, 1'b1), "t2 mode min");
    add(MD, os(2'd3, 1'b1), "t2 mode sec");
    add(MD, os(2'd1, 1'b1), "t2 mode wrap hour");
    add(MD, os(2'd2, 1'b1), "t2 mode min2");
    add(UP, op(0, 1, 0, 2'd2, 1'b0), "t2 min_up");
    add(NOP, os(2'd2, 1'b0), "t2 idle1");
    add(NOP, os(2'd2, 1'b0), "t2 idle2");
    add(NOP, os(2'd2, 1'b1), "t2 blink toggle");
    add(OK, COMO, "t2 ok");
    add(NOP, RUNO, "t2 run");
    // test 5: priority ok > mode > up
    add(MD, os(2'd1, 1'b1), "t5 mode hour");
    add(5'b01100, os(2'd2, 1'b1), "t5 mode beats up");
    add(5'b01101, COMO, "t5 ok beats mode");
    add(NOP, RUNO, "t5 run");

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n].i, tbl[n].o, tnm[n]);

    // test 3: auto-repeat in SET_SEC
    apply(MD, os(2'd1, 1'b1), "t3 mode hour");
    apply(MD, os(2'd2, 1'b1), "t3 mode min");
    apply(MD, os(2'd3, 1'b1), "t3 mode sec");
    for (int k = 1; k <= 10; k++)
      apply(LVL, op(0, 0, (k >= 4) && (k % 2 == 0), 2'd3, k <= 2),
            $sformatf("t3 hold%0d", k));
    apply(NOP, os(2'd3, 1'b0), "t3 release1");
    apply(NOP, os(2'd3, 1'b0), "t3 release2");
    apply(NOP, os(2'd3, 1'b1), "t3 release3");
    apply(NOP, os(2'd3, 1'b1), "t3 release4");
    apply(OK, COMO, "t3 ok");
    apply(NOP, RUNO, "t3 run");

    // test 4: idle timeout from SET_HOUR, no enter
    apply(MD, os(2'd1, 1'b1), "t4 mode hour");
    for (int k = 1; k <= 19; k++)
      apply(NOP, os(2'd1, ((k / 3) % 2) == 0), $sformatf("t4 idle%0d", k));
    apply(NOP, RUNO, "t4 timeout");
    apply(NOP, RUNO, "t4 run");

    // test 6: reset mid-set with the up key held
    apply(MD, os(2'd1, 1'b1), "t6 mode hour");
    apply(LVL, os(2'd1, 1'b1), "t6 hold1");
    apply(LVL, os(2'd1, 1'b1), "t6 hold2");
    apply(LVL, os(2'd1, 1'b0), "t6 hold3");
    apply(5'b10010, RUNO, "t6 reset");
    for (int k = 1; k <= 8; k++) apply(LVL, RUNO, $sformatf("t6 post-reset hold%0d", k));
    apply(NOP, RUNO, "t6 release");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d expected values left", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
